// File: rtl/vga_pkg.sv
// Shared VGA constants, decode struct and width helpers for the sprite display.
// Defaults describe the 640x480 mode with a 32x32 sprite on a 3-bit palette.
// Pure definitions: no logic, no latency, no flow control.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit DEF_SYNC_POL = 1'b0;
  localparam int DEF_PIX_DIV  = 2;
  localparam int DEF_RGB_W    = 3;
  localparam int DEF_SPR_W    = 32;
  localparam int DEF_SPR_H    = 32;
  localparam int DEF_STEP     = 4;

  // Foreground defaults to all-ones at whatever colour width is in use.
  localparam int DEF_BG_COLOR     = 0;
  localparam int DEF_BORDER_COLOR = 1;

  // Active-high decode of the raw counters, before polarity and registering.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } vga_dec_t;

  // Counter width needed to hold 0..total-1 for one axis.
  function automatic int total_w(input int act, input int fp, input int sync, input int bp);
    return $clog2(act + fp + sync + bp);
  endfunction

endpackage

// File: rtl/vga_sprite_display_if.sv
// VGA connector bundle: sync pins, colour and the aligned active-area flag.
// All signals are registered by the driver and change together on a pixel tick.
// No flow control; the display samples whatever is driven.
interface vga_sprite_display_if #(
  parameter int RGB_W = 3
);
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [RGB_W-1:0] rgb;

  modport master (output hsync, vsync, video_on, rgb);
  modport slave  (input  hsync, vsync, video_on, rgb);
endinterface

// File: rtl/vga_timing.sv
// Video timing: pixel divider, h/v counters, sync/active decode, frame-start strobe.
// Decode is combinational from the counters; counters advance one step per tick.
// Free-running, no backpressure.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIX_DIV  = DEF_PIX_DIV,
  localparam int XW = total_w(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int YW = total_w(V_ACTIVE, V_FP, V_SYNC, V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          tick_o,
  output logic          frame_start_o,
  output logic [XW-1:0] h_o,
  output logic [YW-1:0] v_o,
  output vga_dec_t      dec_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(PIX_DIV - 1);
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_LAST = YW'(V_ACTIVE - 1);

  // Sync windows compared one bit wider so an end bound equal to the total cannot alias.
  localparam logic [XW:0] H_ACT  = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0] HS_BEG = (XW+1)'(H_ACTIVE + H_FP);
  localparam logic [XW:0] HS_END = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW:0] V_ACT  = (YW+1)'(V_ACTIVE);
  localparam logic [YW:0] VS_BEG = (YW+1)'(V_ACTIVE + V_FP);
  localparam logic [YW:0] VS_END = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic          tick, h_wrap;

  // With PIX_DIV = 1 the divider stays at 0 and the tick is permanently high.
  assign tick   = (div_q == DIV_LAST);
  assign h_wrap = (h_q == H_LAST);

  // Next-state for divider and raster counters; counters hold between ticks.
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
    end
  end

  // Divider and raster counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Active-high decode of the current raster position.
  always_comb begin
    dec_o.hsync  = ({1'b0, h_q} >= HS_BEG) && ({1'b0, h_q} < HS_END);
    dec_o.vsync  = ({1'b0, v_q} >= VS_BEG) && ({1'b0, v_q} < VS_END);
    dec_o.active = ({1'b0, h_q} < H_ACT) && ({1'b0, v_q} < V_ACT);
  end

  // Frame start is the tick that wraps h and moves v into the first blank line.
  assign frame_start_o = tick && h_wrap && (v_q == V_ACT_LAST);
  assign tick_o        = tick;
  assign h_o           = h_q;
  assign v_o           = v_q;

endmodule

// File: rtl/vga_sprite_display.sv
// VGA sprite display: timing, button-driven sprite movement and pixel colouring.
// Pins lag the raster counters by one pixel; frame_tick and position lag frame start by one clk.
// Free-running video output, no backpressure; buttons sampled once per frame.
module vga_sprite_display
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int PIX_DIV  = DEF_PIX_DIV,
  parameter int RGB_W    = DEF_RGB_W,
  parameter int SPR_W    = DEF_SPR_W,
  parameter int SPR_H    = DEF_SPR_H,
  parameter int STEP     = DEF_STEP,
  parameter logic [RGB_W-1:0] FG_COLOR     = '1,
  parameter logic [RGB_W-1:0] BG_COLOR     = RGB_W'(DEF_BG_COLOR),
  parameter logic [RGB_W-1:0] BORDER_COLOR = RGB_W'(DEF_BORDER_COLOR),
  localparam int XW = total_w(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int YW = total_w(V_ACTIVE, V_FP, V_SYNC, V_BP)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        u,
  input  logic                        d,
  input  logic                        l,
  input  logic                        r,
  vga_sprite_display_if.master        vga,
  output logic                        frame_tick,
  output logic [XW-1:0]               pos_x,
  output logic [YW-1:0]               pos_y
);

  localparam logic [XW-1:0] X_RST      = XW'((H_ACTIVE - SPR_W) / 2);
  localparam logic [YW-1:0] Y_RST      = YW'((V_ACTIVE - SPR_H) / 2);
  localparam logic [XW:0]   X_MAX      = (XW+1)'(H_ACTIVE - SPR_W);
  localparam logic [YW:0]   Y_MAX      = (YW+1)'(V_ACTIVE - SPR_H);
  localparam logic [XW:0]   X_STEP     = (XW+1)'(STEP);
  localparam logic [YW:0]   Y_STEP     = (YW+1)'(STEP);
  localparam logic [XW:0]   X_SPR      = (XW+1)'(SPR_W);
  localparam logic [YW:0]   Y_SPR      = (YW+1)'(SPR_H);
  localparam logic [XW-1:0] H_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] V_ACT_LAST = YW'(V_ACTIVE - 1);

  logic          tick;
  logic          frame_start;
  logic [XW-1:0] h;
  logic [YW-1:0] v;
  vga_dec_t      dec;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .PIX_DIV  (PIX_DIV)
  ) u_timing (
    .clk           (clk),
    .rst_n         (reset),
    .tick_o        (tick),
    .frame_start_o (frame_start),
    .h_o           (h),
    .v_o           (v),
    .dec_o         (dec)
  );

  // Buttons packed as {u, d, l, r}.
  logic [3:0] btn_meta_q, btn_sync_q;
  logic       btn_u, btn_d, btn_l, btn_r;

  // Two-flop synchroniser; bounce is harmless because movement samples once per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      btn_meta_q <= {u, d, l, r};
      btn_sync_q <= btn_meta_q;
    end
  end

  assign {btn_u, btn_d, btn_l, btn_r} = btn_sync_q;

  logic [XW-1:0]    pos_x_q, pos_x_d;
  logic [YW-1:0]    pos_y_q, pos_y_d;
  logic             in_sprite, on_border;
  logic [RGB_W-1:0] rgb_d;

  // Colour of the pixel currently addressed by the counters: blank, sprite, border, background.
  always_comb begin
    in_sprite = (h >= pos_x_q) && ({1'b0, h} < ({1'b0, pos_x_q} + X_SPR)) &&
                (v >= pos_y_q) && ({1'b0, v} < ({1'b0, pos_y_q} + Y_SPR));
    on_border = (h == '0) || (h == H_ACT_LAST) || (v == '0) || (v == V_ACT_LAST);
    rgb_d     = '0;
    if (dec.active) begin
      if (in_sprite)      rgb_d = FG_COLOR;
      else if (on_border) rgb_d = BORDER_COLOR;
      else                rgb_d = BG_COLOR;
    end
  end

  logic             hsync_q, vsync_q, video_on_q;
  logic [RGB_W-1:0] rgb_q;

  // Sync, blanking and colour registered together on each tick so the pins stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
      video_on_q <= 1'b0;
      rgb_q      <= '0;
    end else if (tick) begin
      hsync_q    <= dec.hsync ? SYNC_POL : ~SYNC_POL;
      vsync_q    <= dec.vsync ? SYNC_POL : ~SYNC_POL;
      video_on_q <= dec.active;
      rgb_q      <= rgb_d;
    end
  end

  // Saturating sprite step per axis; opposing buttons cancel and hold the axis.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (btn_u && !btn_d) begin
      pos_y_d = ({1'b0, pos_y_q} >= Y_STEP) ? YW'({1'b0, pos_y_q} - Y_STEP) : '0;
    end else if (btn_d && !btn_u) begin
      pos_y_d = (({1'b0, pos_y_q} + Y_STEP) > Y_MAX) ? YW'(Y_MAX) : YW'({1'b0, pos_y_q} + Y_STEP);
    end
    if (btn_l && !btn_r) begin
      pos_x_d = ({1'b0, pos_x_q} >= X_STEP) ? XW'({1'b0, pos_x_q} - X_STEP) : '0;
    end else if (btn_r && !btn_l) begin
      pos_x_d = (({1'b0, pos_x_q} + X_STEP) > X_MAX) ? XW'(X_MAX) : XW'({1'b0, pos_x_q} + X_STEP);
    end
  end

  // Position only moves at frame start, so the visible frame never tears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_tick <= 1'b0;
      pos_x_q    <= X_RST;
      pos_y_q    <= Y_RST;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) begin
        pos_x_q <= pos_x_d;
        pos_y_q <= pos_y_d;
      end
    end
  end

  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.video_on = video_on_q;
  assign vga.rgb      = rgb_q;
  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;

endmodule

// File: tb/tb_vga_sprite_display.sv
// Bench for vga_sprite_display: a reduced-timing instance and a default 640-wide instance.
// Expectations are queued when stimulus is applied and popped at each output sample.
// Outputs are sampled 1 time unit after the rising clock edge.
module tb_vga_sprite_display;

  localparam int AXW = 4;
  localparam int AYW = 4;
  localparam int BXW = 10;
  localparam int BYW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  logic ua, da, la, ra, ub, db, lb, rb;
  logic ft_a, ft_b;
  logic [AXW-1:0] px_a;
  logic [AYW-1:0] py_a;
  logic [BXW-1:0] px_b;
  logic [BYW-1:0] py_b;

  vga_sprite_display_if #(.RGB_W(3)) vif_a ();
  vga_sprite_display_if #(.RGB_W(3)) vif_b ();

  vga_sprite_display #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIX_DIV(2), .SPR_W(2), .SPR_H(2), .STEP(1)
  ) dut_a (
    .clk(clk), .reset(rst_a_n), .u(ua), .d(da), .l(la), .r(ra),
    .vga(vif_a), .frame_tick(ft_a), .pos_x(px_a), .pos_y(py_a)
  );

  // Default timing; a tall sprite places its top edge on line 16 so it is reached quickly.
  vga_sprite_display #(
    .PIX_DIV(1), .SPR_H(448)
  ) dut_b (
    .clk(clk), .reset(rst_b_n), .u(ub), .d(db), .l(lb), .r(rb),
    .vga(vif_b), .frame_tick(ft_b), .pos_x(px_b), .pos_y(py_b)
  );

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic compare(input logic [31:0] obs);
    string       tag;
    logic [31:0] ev;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $error("FAIL sb_underflow: observed %0d with no expectation queued", obs);
    end else begin
      tag = tag_q.pop_front();
      ev  = exp_q.pop_front();
      assert (obs === ev) else begin
        n_miss++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, ev);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for frame_tick on instance A; px_before is pos_x in the sample just before it.
  task automatic wait_ft_a(input int budget, output logic [31:0] seen, output logic [31:0] px_before);
    seen      = 0;
    px_before = 32'(px_a);
    for (int i = 0; i < budget && seen == 0; i++) begin
      px_before = 32'(px_a);
      step();
      if (ft_a) seen = 1;
    end
  endtask

  function automatic logic [31:0] model_b(input int h, input int v);
    if (h >= 640 || v >= 480) return 0;
    if (h >= 304 && h < 336 && v >= 16 && v < 464) return 7;
    if (h == 0 || h == 639 || v == 0 || v == 479) return 1;
    return 0;
  endfunction

  int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], ft_edges[$];
  logic hs_prev, vs_prev;
  logic [31:0] s_vo1, s_vo2, s_rgb2, s_rgb14, s_rgb20, s_vo20, s_rgb54, s_rgb56, s_rgb57, s_rgb58, s_rgb60;
  logic [31:0] seen, pxb;
  int first_hs, first_ft, hh, vv;
  logic [31:0] px_at_ft;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    ua = 0; da = 0; la = 0; ra = 0; ub = 0; db = 0; lb = 0; rb = 0;
    repeat (3) step();

    // Reset state of both instances.
    expect_val("a_rst_hsync", 1); compare(32'(vif_a.hsync));
    expect_val("a_rst_vsync", 1); compare(32'(vif_a.vsync));
    expect_val("a_rst_rgb", 0);   compare(32'(vif_a.rgb));
    expect_val("a_rst_vo", 0);    compare(32'(vif_a.video_on));
    expect_val("a_rst_ft", 0);    compare(32'(ft_a));
    expect_val("a_rst_px", 3);    compare(32'(px_a));
    expect_val("a_rst_py", 2);    compare(32'(py_a));
    expect_val("b_rst_px", 304);  compare(32'(px_b));
    expect_val("b_rst_py", 16);   compare(32'(py_b));
    expect_val("b_rst_hsync", 1); compare(32'(vif_b.hsync));
    expect_val("b_rst_ft", 0);    compare(32'(ft_b));

    // Free run after release, no buttons: timing, first pixels, frame strobe.
    expect_val("a_vo_e1", 0);
    expect_val("a_vo_e2", 1);
    expect_val("a_rgb_e2_border", 1);
    expect_val("a_rgb_e14_top_border", 1);
    expect_val("a_rgb_e20_hblank", 0);
    expect_val("a_vo_e20_hblank", 0);
    expect_val("a_rgb_e54_bg", 0);
    expect_val("a_rgb_e56_sprite", 7);
    expect_val("a_rgb_e57_sprite_hold", 7);
    expect_val("a_rgb_e58_sprite", 7);
    expect_val("a_rgb_e60_bg", 0);
    expect_val("a_hs_first_fall", 20);
    expect_val("a_hs_low_clks", 4);
    expect_val("a_hs_period", 24);
    expect_val("a_vs_first_fall", 170);
    expect_val("a_vs_low_clks", 24);
    expect_val("a_ft_count", 2);
    expect_val("a_ft_first", 144);
    expect_val("a_ft_period", 216);
    expect_val("a_idle_px", 3);
    expect_val("a_idle_py", 2);
    @(negedge clk);
    rst_a_n = 1'b1;
    hs_prev = 1'b1; vs_prev = 1'b1;
    for (int c = 1; c <= 500; c++) begin
      step();
      if (hs_prev && !vif_a.hsync) hs_fall.push_back(c);
      if (!hs_prev && vif_a.hsync) hs_rise.push_back(c);
      if (vs_prev && !vif_a.vsync) vs_fall.push_back(c);
      if (!vs_prev && vif_a.vsync) vs_rise.push_back(c);
      if (ft_a) ft_edges.push_back(c);
      hs_prev = vif_a.hsync; vs_prev = vif_a.vsync;
      if (c == 1)  s_vo1   = 32'(vif_a.video_on);
      if (c == 2)  begin s_vo2 = 32'(vif_a.video_on); s_rgb2 = 32'(vif_a.rgb); end
      if (c == 14) s_rgb14 = 32'(vif_a.rgb);
      if (c == 20) begin s_rgb20 = 32'(vif_a.rgb); s_vo20 = 32'(vif_a.video_on); end
      if (c == 54) s_rgb54 = 32'(vif_a.rgb);
      if (c == 56) s_rgb56 = 32'(vif_a.rgb);
      if (c == 57) s_rgb57 = 32'(vif_a.rgb);
      if (c == 58) s_rgb58 = 32'(vif_a.rgb);
      if (c == 60) s_rgb60 = 32'(vif_a.rgb);
    end
    compare(s_vo1); compare(s_vo2); compare(s_rgb2); compare(s_rgb14);
    compare(s_rgb20); compare(s_vo20); compare(s_rgb54); compare(s_rgb56);
    compare(s_rgb57); compare(s_rgb58); compare(s_rgb60);
    compare(hs_fall.size() > 0 ? 32'(hs_fall[0]) : 32'hFFFF_FFFF);
    compare((hs_fall.size() > 0 && hs_rise.size() > 0) ? 32'(hs_rise[0] - hs_fall[0]) : 32'hFFFF_FFFF);
    compare(hs_fall.size() > 1 ? 32'(hs_fall[1] - hs_fall[0]) : 32'hFFFF_FFFF);
    compare(vs_fall.size() > 0 ? 32'(vs_fall[0]) : 32'hFFFF_FFFF);
    compare((vs_fall.size() > 0 && vs_rise.size() > 0) ? 32'(vs_rise[0] - vs_fall[0]) : 32'hFFFF_FFFF);
    compare(32'(ft_edges.size()));
    compare(ft_edges.size() > 0 ? 32'(ft_edges[0]) : 32'hFFFF_FFFF);
    compare(ft_edges.size() > 1 ? 32'(ft_edges[1] - ft_edges[0]) : 32'hFFFF_FFFF);
    compare(32'(px_a)); compare(32'(py_a));

    // Hold r for 10 frames: x steps to the right edge limit and stays.
    ra = 1'b1;
    for (int f = 0; f < 10; f++) begin
      expect_val("r_hold_tick_seen", 1);
      expect_val("r_hold_px_before", (f == 0) ? 3 : ((3 + f > 6) ? 6 : 3 + f));
      expect_val("r_hold_px", (4 + f > 6) ? 6 : 4 + f);
      expect_val("r_hold_py", 2);
      wait_ft_a(300, seen, pxb);
      compare(seen); compare(pxb); compare(32'(px_a)); compare(32'(py_a));
    end

    // Opposing vertical buttons hold the axis.
    ra = 1'b0; ua = 1'b1; da = 1'b1;
    for (int f = 0; f < 3; f++) begin
      expect_val("ud_tick_seen", 1);
      expect_val("ud_py", 2);
      expect_val("ud_px", 6);
      wait_ft_a(300, seen, pxb);
      compare(seen); compare(32'(py_a)); compare(32'(px_a));
    end

    // u alone: y saturates at the top.
    da = 1'b0;
    for (int f = 0; f < 5; f++) begin
      expect_val("u_tick_seen", 1);
      expect_val("u_py", (f == 0) ? 1 : 0);
      wait_ft_a(300, seen, pxb);
      compare(seen); compare(32'(py_a));
    end

    // Short l pulse between frame updates is never sampled.
    ua = 1'b0;
    repeat (20) step();
    la = 1'b1;
    repeat (3) step();
    la = 1'b0;
    expect_val("lpulse_tick_seen", 1);
    expect_val("lpulse_px", 6);
    expect_val("lpulse_py", 0);
    wait_ft_a(300, seen, pxb);
    compare(seen); compare(32'(px_a)); compare(32'(py_a));

    // Mid-frame reset with r held on instance A.
    ra = 1'b1;
    repeat (130) step();
    expect_val("a_midrst_vo_before", 1); compare(32'(vif_a.video_on));
    expect_val("a_midrst_px_before", 6); compare(32'(px_a));
    #2;
    rst_a_n = 1'b0;
    #1;
    expect_val("a_midrst_hsync", 1); compare(32'(vif_a.hsync));
    expect_val("a_midrst_vsync", 1); compare(32'(vif_a.vsync));
    expect_val("a_midrst_rgb", 0);   compare(32'(vif_a.rgb));
    expect_val("a_midrst_vo", 0);    compare(32'(vif_a.video_on));
    expect_val("a_midrst_ft", 0);    compare(32'(ft_a));
    expect_val("a_midrst_px", 3);    compare(32'(px_a));
    expect_val("a_midrst_py", 2);    compare(32'(py_a));
    repeat (2) @(negedge clk);
    expect_val("a_rel_first_hs_fall", 20);
    expect_val("a_rel_first_ft", 144);
    expect_val("a_rel_px_at_ft", 4);
    rst_a_n = 1'b1;
    first_hs = -1; first_ft = -1; px_at_ft = '1;
    for (int c = 1; c <= 300 && first_ft < 0; c++) begin
      step();
      if (first_hs < 0 && !vif_a.hsync) first_hs = c;
      if (ft_a) begin first_ft = c; px_at_ft = 32'(px_a); end
    end
    compare(32'(first_hs)); compare(32'(first_ft)); compare(px_at_ft);
    ra = 1'b0;

    // Instance B: default timing, one pixel per clk; colours around the sprite's top row.
    @(negedge clk);
    rst_b_n = 1'b1;
    for (int e = 1; e <= 17 * 800; e++) begin
      step();
      hh = (e - 1) % 800;
      vv = (e - 1) / 800;
      if ((vv == 16 && hh >= 300 && hh <= 340) ||
          (vv == 16 && (hh == 0 || hh == 639 || hh == 650 || hh == 700)) ||
          (vv == 0 && (hh == 5 || hh == 320)) ||
          (vv == 5 && (hh == 100 || hh == 320)) ||
          (vv == 15 && hh == 320)) begin
        expect_val($sformatf("b_rgb_v%0d_h%0d", vv, hh), model_b(hh, vv));
        compare(32'(vif_b.rgb));
      end
      if (vv == 16 && (hh == 639 || hh == 640)) begin
        expect_val($sformatf("b_vo_v%0d_h%0d", vv, hh), (hh < 640) ? 1 : 0);
        compare(32'(vif_b.video_on));
      end
    end

    // Mid-line reset on instance B with r held, then time to the first hsync.
    rb = 1'b1;
    repeat (200) step();
    expect_val("b_midrst_vo_before", 1); compare(32'(vif_b.video_on));
    #2;
    rst_b_n = 1'b0;
    #1;
    expect_val("b_midrst_hsync", 1); compare(32'(vif_b.hsync));
    expect_val("b_midrst_vsync", 1); compare(32'(vif_b.vsync));
    expect_val("b_midrst_rgb", 0);   compare(32'(vif_b.rgb));
    expect_val("b_midrst_vo", 0);    compare(32'(vif_b.video_on));
    expect_val("b_midrst_px", 304);  compare(32'(px_b));
    expect_val("b_midrst_py", 16);   compare(32'(py_b));
    repeat (2) @(negedge clk);
    // 656 ticks after the first one, i.e. registered at the 657th edge after release.
    expect_val("b_rel_first_hs_fall", 657);
    rst_b_n = 1'b1;
    first_hs = -1;
    for (int c = 1; c <= 1000 && first_hs < 0; c++) begin
      step();
      if (!vif_b.hsync) first_hs = c;
    end
    compare(32'(first_hs));
    rb = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
